// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader.
package bram_reader_pkg;

  localparam int RD_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_reader_fifo.sv
// First-word-fall-through output buffer for the stream reader; count feeds the
// reader's credit logic. Simultaneous push and pop on a full buffer is accepted.
module bram_reader_fifo #(
  parameter int data_width = 32,
  parameter int fifo_depth = 4,
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1,
  localparam int CW = $clog2(fifo_depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] wr_data,
  input  logic                  pop,
  output logic [data_width-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count
);

  logic [data_width-1:0] mem [fifo_depth];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(fifo_depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The reader's credit rule must never let a word land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read master for the 2-cycle-latency block RAM, delivering words on a
// valid/ready stream. Optional BRAM_READER_STATS_EN adds a stall_cycles counter.
//
// Handshake: a word transfers on any clock edge where out_valid && out_ready;
// out_valid never drops and out_data never changes until that transfer happens.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 10,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [addr_width-1:0] start_addr,
  input  logic [addr_width:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] bram_rd_addr,
  input  logic [data_width-1:0] bram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output state_t                dbg_state
`ifdef BRAM_READER_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int CW    = $clog2(fifo_depth + 1);
  localparam int CNT_W = addr_width + 1;

  if (fifo_depth < RD_LATENCY + 1) begin : g_bad_depth
    $error("bram_stream_reader: fifo_depth must be at least RD_LATENCY+1");
  end

  state_t                state;
  logic [addr_width-1:0] addr;
  logic [CNT_W-1:0]      remaining;
  logic                  rd_vld;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [1:0]            inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  issue;
  logic                  last_pop;
  int                    credit_used;

  // rd_vld marks the cycle an address sits on the RAM port; the shift register
  // then follows it through the RAM latency so stage 2 lines up with the data.
  assign inflight  = 2'(rd_vld) + 2'(vld_sr[0]) + 2'(vld_sr[1]);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (fifo_count == CW'(1)) && (inflight == 2'd0);
  assign dbg_state = state;

  // A word leaving this cycle frees its slot, which keeps one word per cycle
  // flowing when the consumer is always ready.
  always_comb begin
    credit_used = int'(fifo_count) + int'(inflight) - int'(pop);
    issue       = (state == ISSUE) && (credit_used < fifo_depth);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bram_rd_addr <= '0;
      addr         <= '0;
      remaining    <= '0;
      rd_vld       <= 1'b0;
      vld_sr       <= '0;
    end else begin
      rd_vld <= issue;
      vld_sr <= {vld_sr[0], rd_vld};
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            addr      <= start_addr;
            remaining <= count;
            busy      <= 1'b1;
            if (count != '0) begin
              state <= ISSUE;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            bram_rd_addr <= addr;
            addr         <= addr + 1'b1;
            remaining    <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_reader_fifo #(
    .data_width (data_width),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (vld_sr[RD_LATENCY-1]),
    .wr_data (bram_rd_data),
    .pop     (pop),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

`ifdef BRAM_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && go) begin
      stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a 2-cycle-latency RAM model.
// Define BRAM_READER_STATS_EN to also exercise stall_cycles.
module tb_bram_stream_reader;
  import bram_reader_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int RAM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  state_t        dbg_state;
`ifdef BRAM_READER_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  bram_stream_reader #(
    .data_width (DW),
    .addr_width (AW),
    .fifo_depth (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .start_addr   (start_addr),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .dbg_state    (dbg_state)
`ifdef BRAM_READER_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model: mem[A] appears two cycles after A ----------------
  logic [DW-1:0] ram [RAM_N];
  logic [DW-1:0] ram_d1;

  always @(posedge clk) begin
    ram_d1       <= ram[bram_rd_addr];
    bram_rd_data <= ram_d1;
  end

  // ---------------- consumer ready driver ----------------
  int         rdy_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1, other: never
  int         rdy_ph   = 0;
  logic [3:0] rdy_pat  = 4'b1001;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = rdy_pat[rdy_ph];
          rdy_ph    = (rdy_ph + 1) % 4;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0d expected no word", out_data);
        end else begin
          check("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_go(input int sa, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(DW'(((sa + i) % RAM_N) + 100));
    @(posedge clk);
    #1;
    start_addr = AW'(sa);
    count      = (AW + 1)'(cnt);
    go         = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic finish_burst(input string name, input int d0, input int cnt);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_word_count"}, pop_cnt, cnt);
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic run_burst(input string name, input int sa, input int cnt);
    int d0;
    d0      = done_cnt;
    pop_cnt = 0;
    issue_go(sa, cnt);
    finish_burst(name, d0, cnt);
  endtask

  // ---------------- stimulus ----------------
  int a0;
  int d0;
  int t;

  initial begin
    rst        = 1'b1;
    go         = 1'b0;
    start_addr = '0;
    count      = '0;
    for (int i = 0; i < RAM_N; i++) ram[i] = DW'(i + 100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_addr", int'(bram_rd_addr), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Straight burst, consumer always ready: words must come back to back.
    run_burst("t1", 5, 8);
    check("t1_back_to_back", last_pop_cyc - first_pop_cyc, 7);

    // Same burst with a stuttering consumer.
    rdy_mode = 1;
    run_burst("t2", 5, 8);
    rdy_mode = 0;

    // Address wrap at the top of the RAM, then a whole-RAM burst.
    run_burst("t3", 14, 4);
    run_burst("full", 3, 16);

    // Zero-length burst: done next cycle, no reads, no words.
    a0 = int'(bram_rd_addr);
    d0 = done_cnt;
    issue_go(7, 0);
    @(negedge clk);
    check("t4_done", int'(done), 1);
    check("t4_busy", int'(busy), 1);
    @(negedge clk);
    check("t4_done_low", int'(done), 0);
    check("t4_busy_low", int'(busy), 0);
    check("t4_addr", int'(bram_rd_addr), a0);
    check("t4_done_cnt", done_cnt - d0, 1);

    // Reset in the middle of a burst discards it entirely.
    rdy_mode = 3;
    issue_go(5, 8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_done", int'(done), 0);
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_addr", int'(bram_rd_addr), 0);
    check("t5_rst_state", int'(dbg_state), int'(IDLE));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_no_stale_word", int'(out_valid), 0);
    run_burst("t5", 0, 2);

`ifdef BRAM_READER_STATS_EN
    // Ten stalled cycles mid-burst, then the next go clears the counter.
    d0      = done_cnt;
    pop_cnt = 0;
    issue_go(5, 8);
    t = 0;
    while (pop_cnt < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    rdy_mode = 3;
    repeat (10) @(posedge clk);
    rdy_mode = 0;
    finish_burst("t6", d0, 8);
    check("t6_stall_cycles", int'(stall_cycles), 10);
    d0      = done_cnt;
    pop_cnt = 0;
    issue_go(0, 2);
    @(negedge clk);
    check("t6_stall_cleared", int'(stall_cycles), 0);
    finish_burst("t6b", d0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
